// File: rtl/rle_pkg.sv
// Shared definitions for the RLE decoder: controller states and pair field layout.
// The pair field offsets must stay identical to the ones the encoder uses.
package rle_pkg;

    localparam int PAIR_W     = 16;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = PAIR_W * 2;

    localparam int BYTE_HI = 15;
    localparam int BYTE_LO = 8;
    localparam int CNT_HI  = 7;
    localparam int CNT_LO  = 0;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        EXPAND,
        WR,
        FLUSH
    } state_t;

endpackage

// File: rtl/rle_byte_packer.sv
// Packs decoded bytes LSB-first into a 32-bit write buffer.
// full flags that the next push completes the word.
module rle_byte_packer
    import rle_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              clear,
    input  logic              push,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              full,
    output logic              pending,
    output logic [WORD_W-1:0] data
);

    localparam int LANE_W = $clog2(WORD_BYTES);

    logic [LANE_W-1:0] lane;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lane <= '0;
            data <= '0;
        end else if (clear) begin
            lane <= '0;
            data <= '0;
        end else if (push) begin
            data[lane*BYTE_W +: BYTE_W] <= byte_in;
            lane                        <= lane + LANE_W'(1);
        end
    end

    assign full    = (lane == LANE_W'(WORD_BYTES - 1));
    assign pending = (lane != '0);

endmodule

// File: rtl/rle_decoder.sv
// Expands an RLE frame ({byte,count} pairs, two per word) from SRAM back into
// plaintext, writing packed words through the same single SRAM port.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int SIZE_W = 32
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       out_addr,
    output logic [SIZE_W-1:0] out_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    state_t state, state_next;

    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [SIZE_W-1:0] words_left, size_cnt;
    logic [WORD_W-1:0] word_reg, wr_buf;
    logic [BYTE_W-1:0] cnt_left, cur_byte, hi_cnt;
    logic              pair_idx;
    logic              push, clear, full, pending, done_set, pairs_done;
    logic              unused_hi;

    assign unused_hi  = ^{rle_addr[31:ADDR_W], out_addr[31:ADDR_W]};
    assign port_A_clk = clk;
    assign out_size   = size_cnt;

    assign cur_byte   = pair_idx ? word_reg[PAIR_W+BYTE_HI : PAIR_W+BYTE_LO]
                                 : word_reg[BYTE_HI : BYTE_LO];
    assign hi_cnt     = word_reg[PAIR_W+CNT_HI : PAIR_W+CNT_LO];
    assign push       = (state == EXPAND) && (cnt_left != '0);
    assign pairs_done = pair_idx && (cnt_left == '0);

    rle_byte_packer u_packer (
        .clk     (clk),
        .nreset  (nreset),
        .clear   (clear),
        .push    (push),
        .byte_in (cur_byte),
        .full    (full),
        .pending (pending),
        .data    (wr_buf)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    // An empty frame walks through EXPAND with both pairs exhausted.
                    state_next = (rle_size == '0) ? EXPAND : RD_REQ;
                end
            end
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: state_next = EXPAND;
            EXPAND: begin
                if (push) begin
                    if (full)
                        state_next = WR;
                    else if (pair_idx && cnt_left == BYTE_W'(1))
                        state_next = (words_left != '0) ? RD_REQ : FLUSH;
                end else if (pair_idx) begin
                    if (words_left != '0) begin
                        state_next = RD_REQ;
                    end else if (pending) begin
                        state_next = FLUSH;
                    end else begin
                        state_next = IDLE;
                        done_set   = 1'b1;
                    end
                end
            end
            WR: begin
                clear = 1'b1;
                if (!pairs_done) begin
                    state_next = EXPAND;
                end else if (words_left != '0) begin
                    state_next = RD_REQ;
                end else begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end
            FLUSH: begin
                clear      = 1'b1;
                state_next = IDLE;
                done_set   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_addr    <= '0;
            wr_addr    <= '0;
            words_left <= '0;
            size_cnt   <= '0;
            word_reg   <= '0;
            cnt_left   <= '0;
            pair_idx   <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (done_set) done <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr    <= rle_addr[ADDR_W-1:0];
                        wr_addr    <= out_addr[ADDR_W-1:0];
                        words_left <= SIZE_W'(rle_size >> 2);
                        size_cnt   <= '0;
                        pair_idx   <= 1'b1;
                        cnt_left   <= '0;
                        done       <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    word_reg   <= port_A_data_out;
                    cnt_left   <= port_A_data_out[CNT_HI:CNT_LO];
                    pair_idx   <= 1'b0;
                    rd_addr    <= rd_addr + ADDR_W'(WORD_BYTES);
                    words_left <= words_left - SIZE_W'(1);
                end
                EXPAND: begin
                    if (push) begin
                        size_cnt <= size_cnt + SIZE_W'(1);
                        // Moving to the high pair as soon as the low one drains saves a cycle.
                        if (!pair_idx && cnt_left == BYTE_W'(1)) begin
                            pair_idx <= 1'b1;
                            cnt_left <= hi_cnt;
                        end else begin
                            cnt_left <= cnt_left - BYTE_W'(1);
                        end
                    end else if (!pair_idx) begin
                        pair_idx <= 1'b1;
                        cnt_left <= hi_cnt;
                    end
                end
                WR, FLUSH: wr_addr <= wr_addr + ADDR_W'(WORD_BYTES);
                default: ;
            endcase
        end
    end

    always_comb begin
        port_A_we      = 1'b0;
        port_A_addr    = '0;
        port_A_data_in = '0;
        case (state)
            RD_REQ: port_A_addr = rd_addr;
            WR, FLUSH: begin
                port_A_we      = 1'b1;
                port_A_addr    = wr_addr;
                port_A_data_in = wr_buf;
            end
            default: ;
        endcase
    end

endmodule
